// File: rtl/trace_encoder.sv
// trace_encoder: samples an 8-bit probe bundle, timestamps each value change as a
// cycle delta, queues events in a FIFO, and serializes every event as a 4-byte
// packet {header, value, delta_hi, delta_lo} to a UART transmitter.
module trace_encoder #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  HDR_OK     = 8'hA5,
  parameter logic [7:0]  HDR_LOST   = 8'hA6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            wires,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int unsigned         Depth      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthLevel = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0] LevelOne   = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

  // Capture path
  logic [7:0]  s1_q, s2_q, prev_q;
  logic [15:0] timer_q, timer_d;
  logic        change, push;
  logic [23:0] push_data;

  // Event FIFO
  logic [23:0]           mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  full, empty, pop, accept, drop;
  logic                  overflow_q, lost_q, lost_d;

  // Serializer
  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] rec_q, rec_d;
  logic        issue, tx_start_q;
  logic [7:0]  tx_data_q, tx_data_d, cur_byte;

  // Two-flop synchronizer plus previous-value register for change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= wires;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  // Event generation: value change or timer saturation (keepalive)
  always_comb begin
    change  = (s2_q != prev_q);
    push    = 1'b0;
    timer_d = timer_q + 16'd1;
    if (!enable) begin
      timer_d = '0;
    end else if (change || (timer_q == 16'hFFFF)) begin
      push    = 1'b1;
      timer_d = 16'd1;
    end
  end

  assign push_data = {s2_q, timer_q};

  // Delta timer
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign full   = (level_q == DepthLevel);
  assign empty  = (level_q == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO is kept then
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  // Occupancy and lost-event tracking; a drop wins over the header clear
  always_comb begin
    level_d = level_q;
    case ({accept, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
    lost_d = lost_q;
    if (issue && (idx_q == 2'd0) && lost_q) begin
      lost_d = 1'b0;
    end
    if (drop) begin
      lost_d = 1'b1;
    end
  end

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // FIFO pointers, level and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q    <= level_d;
      overflow_q <= overflow_q | drop;
      lost_q     <= lost_d;
    end
  end

  // Serializer state register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rec_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rec_q      <= rec_d;
      tx_start_q <= issue;
      tx_data_q  <= tx_data_d;
    end
  end

  // Serializer next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty) state_d = StIssue;
      StIssue: if (!tx_busy) state_d = StGap;
      // Busy is ignored here: the transmitter raises it one cycle after start
      StGap:   state_d = (idx_q == 2'd3) ? StIdle : StIssue;
      default: state_d = StIdle;
    endcase
  end

  // Serializer outputs: pop/latch, byte issue and index advance
  always_comb begin
    pop       = 1'b0;
    issue     = 1'b0;
    idx_d     = idx_q;
    rec_d     = rec_q;
    tx_data_d = tx_data_q;
    unique case (idx_q)
      2'd0:    cur_byte = lost_q ? HDR_LOST : HDR_OK;
      2'd1:    cur_byte = rec_q[23:16];
      2'd2:    cur_byte = rec_q[15:8];
      default: cur_byte = rec_q[7:0];
    endcase
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop   = 1'b1;
          rec_d = mem_q[rd_ptr_q];
          idx_d = 2'd0;
        end
      end
      StIssue: begin
        if (!tx_busy) begin
          issue     = 1'b1;
          tx_data_d = cur_byte;
        end
      end
      StGap: begin
        if (idx_q != 2'd3) begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_trace_encoder.sv
// tb_trace_encoder: directed, table-driven bench for trace_encoder with a small
// UART transmitter model (busy rises one cycle after tx_start, stays 10 cycles).
module tb_trace_encoder;

  localparam int unsigned DepthLog2 = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b1;
  logic [7:0]           wires = 8'h00;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 overflow;
  logic [DepthLog2:0]   fifo_level;

  logic                 busy_force = 1'b0;
  int unsigned          uart_cnt = 0;
  int                   n_tests = 0;
  int                   n_fail = 0;
  logic [7:0]           rx_q [$];

  typedef struct {
    logic [7:0]  value;
    int unsigned hold;
    logic        has_pkt;
    logic [31:0] pkt;
  } step_t;

  trace_encoder #(
    .DEPTH_LOG2(DepthLog2),
    .HDR_OK    (8'hA5),
    .HDR_LOST  (8'hA6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .wires     (wires),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  assign tx_busy = busy_force | (uart_cnt != 0);

  // UART transmitter model
  always @(posedge clk) begin
    if (tx_start === 1'b1) begin
      uart_cnt <= 10;
    end else if (uart_cnt != 0) begin
      uart_cnt <= uart_cnt - 1;
    end
  end

  // Byte capture and handshake check
  initial begin : monitor
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        rx_q.push_back(tx_data);
        n_tests++;
        if (tx_busy !== 1'b0 || prev_start) begin
          n_fail++;
          $display("FAIL handshake: tx_start=1 with tx_busy=%b prev_start=%b, required 0/0",
                   tx_busy, prev_start);
        end
      end
      prev_start = (tx_start === 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic check_pkt(input string name, input logic [31:0] exp, input logic [31:0] mask);
    logic [31:0] got;
    got = 'x;
    if (rx_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) got = {got[23:0], rx_q.pop_front()};
    end
    check(name, got & mask, exp & mask);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int b;
    b = budget;
    while (rx_q.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (rx_q.size() < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d bytes received, required %0d", rx_q.size(), n);
    end
  endtask

  initial begin
    step_t steps [8];
    int    nb;
    int    npkt;

    // Deltas: a change applied 'hold' cycles after the previous one reports 'hold';
    // the first change 100 cycles after reset release reports 100 + 2 sync cycles.
    steps[0] = '{8'h00, 100,   1'b0, 32'h0};
    steps[1] = '{8'h3C, 300,   1'b1, 32'hA53C_0066};
    steps[2] = '{8'h01, 1,     1'b1, 32'hA501_012C};
    steps[3] = '{8'h02, 1,     1'b1, 32'hA502_0001};
    steps[4] = '{8'h03, 300,   1'b1, 32'hA503_0001};
    steps[5] = '{8'h55, 65535, 1'b1, 32'hA555_012C};
    // Keepalive row: no wire change; timer restarts at 1, so 56 arrives 4465 later
    steps[6] = '{8'h55, 4465,  1'b1, 32'hA555_FFFF};
    steps[7] = '{8'h56, 300,   1'b1, 32'hA556_1171};

    repeat (4) @(negedge clk);
    check("reset tx_start", {31'b0, tx_start}, 32'd0);
    check("reset tx_data", {24'b0, tx_data}, 32'd0);
    check("reset overflow", {31'b0, overflow}, 32'd0);
    check("reset fifo_level", {27'b0, fifo_level}, 32'd0);

    // Timestamp, back-to-back and keepalive sequences
    reset = 1'b0;
    npkt = 0;
    for (int i = 0; i < 8; i++) begin
      wires = steps[i].value;
      repeat (steps[i].hold) @(negedge clk);
      if (steps[i].has_pkt) npkt++;
    end
    wait_bytes(npkt * 4, 500);
    for (int i = 0; i < 8; i++) begin
      if (steps[i].has_pkt) check_pkt($sformatf("packet step%0d", i), steps[i].pkt, 32'hFFFF_FFFF);
    end

    // Overflow: 21 changes with the transmitter held busy; 1 latched, 16 queued, 4 dropped
    busy_force = 1'b1;
    for (int i = 0; i < 21; i++) begin
      wires = 8'h10 + 8'(i);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("saturated fifo_level", {27'b0, fifo_level}, 32'd16);
    check("overflow set", {31'b0, overflow}, 32'd1);
    busy_force = 1'b0;
    wait_bytes(17 * 4, 3000);
    for (int i = 0; i < 17; i++) begin
      check_pkt($sformatf("overflow packet%0d", i),
                {(i == 0) ? 8'hA6 : 8'hA5, 8'h10 + 8'(i), 16'h0001},
                (i == 0) ? 32'hFFFF_0000 : 32'hFFFF_FFFF);
    end
    check("no extra packets", rx_q.size(), 32'd0);
    check("overflow sticky", {31'b0, overflow}, 32'd1);

    // Reset right after byte1 of a packet is issued
    wires = 8'h77;
    nb = 0;
    for (int i = 0; i < 300 && nb < 2; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) nb++;
    end
    check("bytes before reset", nb, 32'd2);
    reset = 1'b1;
    wires = 8'h00;
    @(negedge clk);
    check("abort tx_start", {31'b0, tx_start}, 32'd0);
    check("abort tx_data", {24'b0, tx_data}, 32'd0);
    check("abort fifo_level", {27'b0, fifo_level}, 32'd0);
    check("abort overflow", {31'b0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) nb++;
    end
    check("no bytes after abort", nb, 32'd0);
    rx_q.delete();

    // Capture disabled while toggling, then re-enable with static wires
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wires = 8'h81 + 8'(i);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    enable = 1'b1;
    repeat (50) @(negedge clk);
    check("no packets while disabled/static", rx_q.size(), 32'd0);
    wires = 8'hC3;
    wait_bytes(4, 200);
    check_pkt("delta from enable rise", 32'hA5C3_0034, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
